// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one single-port memory between CPU and DMA requesters, round-robin, one access in flight.
// Latency : gnt 1 cycle after the sampling edge; done 2 cycles after (write/error) or 2+RD_LAT cycles after (read).
// Backpr. : requests are only sampled in IDLE; a requester holds req/operands until gnt, requests seen while busy are ignored.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   cpu_* / dma_*       : req/rw/addr/wdata in; gnt/done/err pulses and rdata out (rw: 1=read, 0=write)
//   mem_addr/rw/dout    : registered memory-side Address/RW/Din
//   mem_din             : memory read data (valid RD_LAT cycles after the issue cycle)
//   *_gnt_cnt, err_cnt  : saturating 8-bit performance counters, present only with ARB_PERF_CNT_EN defined
//
// Build option: define ARB_PERF_CNT_EN to add the grant and error counters.

module mem_bus_arbiter #(
    parameter int N          = 16,
    parameter int AW         = 16,
    parameter int ADDR_LIMIT = 4096,
    parameter int RD_LAT     = 1      // 1..7, counted by a 3-bit counter
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic          cpu_err,
    output logic [N-1:0]  cpu_rdata,

    input  logic          dma_req,
    input  logic          dma_rw,
    input  logic [AW-1:0] dma_addr,
    input  logic [N-1:0]  dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic          dma_err,
    output logic [N-1:0]  dma_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    output logic [N-1:0]  mem_dout,
    input  logic [N-1:0]  mem_din
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [7:0]    cpu_gnt_cnt,
    output logic [7:0]    dma_gnt_cnt,
    output logic [7:0]    err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Extra MSB so a limit equal to 2**AW (nothing illegal) still compares correctly.
    localparam logic [AW:0] LIMIT_EXT = (AW+1)'(ADDR_LIMIT);
    localparam logic [2:0]  RD_LAST   = 3'(RD_LAT - 1);

    state_t state;
    logic   owner;
    logic   last_owner;
    logic   rw_q;        // requested direction (mem_rw is forced to read on errors)
    logic   err_q;
    logic [2:0] rd_cnt;

    // Round-robin: on contention the requester that did not win last time goes first.
    logic          win_cpu, win_dma;
    logic [AW-1:0] sel_addr;
    logic [N-1:0]  sel_wdata;
    logic          sel_rw;
    logic          sel_oor;

    always_comb begin
        win_cpu   = cpu_req && (!dma_req || (last_owner == OWN_DMA));
        win_dma   = dma_req && !win_cpu;
        sel_addr  = win_dma ? dma_addr  : cpu_addr;
        sel_wdata = win_dma ? dma_wdata : cpu_wdata;
        sel_rw    = win_dma ? dma_rw    : cpu_rw;
        sel_oor   = ({1'b0, sel_addr} >= LIMIT_EXT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;   // makes the CPU win the first contended request
            rw_q       <= 1'b1;
            err_q      <= 1'b0;
            rd_cnt     <= 3'd0;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_done   <= 1'b0;
            dma_done   <= 1'b0;
            cpu_err    <= 1'b0;
            dma_err    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            mem_addr   <= '0;
            mem_rw     <= 1'b1;
            mem_dout   <= '0;
        end else begin
            // gnt/done/err are single-cycle pulses
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            cpu_err  <= 1'b0;
            dma_err  <= 1'b0;

            case (state)
                IDLE: begin
                    mem_rw <= 1'b1;
                    if (win_cpu || win_dma) begin
                        owner      <= win_dma;
                        last_owner <= win_dma;
                        cpu_gnt    <= win_cpu;
                        dma_gnt    <= win_dma;
                        mem_addr   <= sel_addr;
                        mem_dout   <= sel_wdata;
                        rw_q       <= sel_rw;
                        err_q      <= sel_oor;
                        // an illegal address must never reach memory as a write
                        mem_rw     <= sel_rw | sel_oor;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    mem_rw <= 1'b1;   // write strobe lasts exactly the issue cycle
                    if (rw_q && !err_q) begin
                        rd_cnt <= 3'd0;
                        state  <= WAIT_RD;
                    end else begin
                        // write or error: respond straight away; errored reads clear rdata
                        if (owner == OWN_DMA) begin
                            dma_done <= 1'b1;
                            dma_err  <= err_q;
                            if (rw_q) dma_rdata <= '0;
                        end else begin
                            cpu_done <= 1'b1;
                            cpu_err  <= err_q;
                            if (rw_q) cpu_rdata <= '0;
                        end
                        state <= RESP;
                    end
                end

                WAIT_RD: begin
                    if (rd_cnt == RD_LAST) begin
                        if (owner == OWN_DMA) begin
                            dma_rdata <= mem_din;
                            dma_done  <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_din;
                            cpu_done  <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        rd_cnt <= rd_cnt + 3'd1;
                    end
                end

                RESP: begin
                    mem_rw <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    mem_rw <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Counters follow the registered pulses, so they lag the visible gnt/done by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_gnt_cnt <= 8'd0;
            dma_gnt_cnt <= 8'd0;
            err_cnt     <= 8'd0;
        end else begin
            if (cpu_gnt && (cpu_gnt_cnt != 8'hFF))
                cpu_gnt_cnt <= cpu_gnt_cnt + 8'd1;
            if (dma_gnt && (dma_gnt_cnt != 8'hFF))
                dma_gnt_cnt <= dma_gnt_cnt + 8'd1;
            if (((cpu_done && cpu_err) || (dma_done && dma_err)) && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : directed bench for mem_bus_arbiter with a transaction-level model compared every cycle.
// Latency : model predicts grant/done cycles from arbitration rules and RD_LAT.
// Backpr. : requesters hold req until gnt, then drop it.

module tb_mem_bus_arbiter;

    localparam int N      = 16;
    localparam int AW     = 16;
    localparam int LIMIT  = 4096;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_rw = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [N-1:0]  cpu_wdata = '0;
    logic          cpu_gnt, cpu_done, cpu_err;
    logic [N-1:0]  cpu_rdata;
    logic          dma_req = 1'b0, dma_rw = 1'b1;
    logic [AW-1:0] dma_addr = '0;
    logic [N-1:0]  dma_wdata = '0;
    logic          dma_gnt, dma_done, dma_err;
    logic [N-1:0]  dma_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [N-1:0]  mem_dout;
    logic [N-1:0]  mem_din;
`ifdef ARB_PERF_CNT_EN
    logic [7:0]    cpu_gnt_cnt, dma_gnt_cnt, err_cnt;
`endif

    always #5 clk = ~clk;

    mem_bus_arbiter #(.N(N), .AW(AW), .ADDR_LIMIT(LIMIT), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_dout(mem_dout), .mem_din(mem_din)
`ifdef ARB_PERF_CNT_EN
        , .cpu_gnt_cnt(cpu_gnt_cnt), .dma_gnt_cnt(dma_gnt_cnt), .err_cnt(err_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory: RD_LAT-deep read pipe, write on mem_rw==0 ----------------
    logic [N-1:0] mem  [0:4095];
    logic [N-1:0] pipe [0:RD_LAT-1];
    assign mem_din = pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (!mem_rw) mem[mem_addr[11:0]] <= mem_dout;
        pipe[0] <= mem[mem_addr[11:0]];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    // ---------------- transaction-level model ----------------
    // g = cycle index of the grant, r = cycle index of the response.
    logic [N-1:0] mmem [0:4095];
    int           cyc = 0;
    int           g = -100, r = -100;
    bit           m_owner = 1'b0, m_last = 1'b1, m_rw = 1'b1, m_err = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [N-1:0]  m_dout = '0, m_rd_cpu = '0, m_rd_dma = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; g = -100; r = -100;
            m_owner = 1'b0; m_last = 1'b1; m_rw = 1'b1; m_err = 1'b0;
            m_addr = '0; m_dout = '0; m_rd_cpu = '0; m_rd_dma = '0;
        end else begin
            cyc++;
            if (cyc == r && m_rw) begin
                if (m_owner) m_rd_dma = m_err ? '0 : mmem[m_addr[11:0]];
                else         m_rd_cpu = m_err ? '0 : mmem[m_addr[11:0]];
            end
            if (cyc >= r + 2 && (cpu_req || dma_req)) begin
                m_owner = (cpu_req && dma_req) ? !m_last : dma_req;
                m_last  = m_owner;
                g       = cyc;
                m_addr  = m_owner ? dma_addr  : cpu_addr;
                m_dout  = m_owner ? dma_wdata : cpu_wdata;
                m_rw    = m_owner ? dma_rw    : cpu_rw;
                m_err   = (32'(m_addr) >= LIMIT);
                r       = (m_rw && !m_err) ? cyc + 1 + RD_LAT : cyc + 1;
                if (!m_rw && !m_err) mmem[m_addr[11:0]] = m_dout;
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_gnt",   32'(cpu_gnt),   32'(g == cyc && !m_owner));
            chk("dma_gnt",   32'(dma_gnt),   32'(g == cyc &&  m_owner));
            chk("cpu_done",  32'(cpu_done),  32'(r == cyc && !m_owner));
            chk("dma_done",  32'(dma_done),  32'(r == cyc &&  m_owner));
            chk("cpu_err",   32'(cpu_err),   32'(r == cyc && !m_owner && m_err));
            chk("dma_err",   32'(dma_err),   32'(r == cyc &&  m_owner && m_err));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rd_cpu));
            chk("dma_rdata", 32'(dma_rdata), 32'(m_rd_dma));
            chk("mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("mem_dout",  32'(mem_dout),  32'(m_dout));
            chk("mem_rw",    32'(mem_rw),    32'(!(g == cyc && !m_rw && !m_err)));
        end
    end

    // ---------------- monitors for hand-computed expectations ----------------
    int gq[$];
    int cpu_done_n = 0;
    int wr_n = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_dat = '0;
    always @(negedge clk) begin
        if (cpu_gnt) gq.push_back(0);
        if (dma_gnt) gq.push_back(1);
        if (cpu_done) cpu_done_n++;
        if (!mem_rw) begin wr_n++; wr_addr = mem_addr; wr_dat = mem_dout; end
    end

    // One transaction; latencies counted in negedges after the edge that samples req.
    task automatic txn(input bit who, input bit rw, input logic [AW-1:0] addr,
                       input logic [N-1:0] wd, output int lat_g, output int lat_d);
        int k;
        bit seen;
        @(negedge clk);
        if (who) begin dma_req = 1'b1; dma_rw = rw; dma_addr = addr; dma_wdata = wd; end
        else     begin cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd; end
        k = 0; seen = 1'b0; lat_g = -1; lat_d = -1;
        while (k < 40 && lat_d < 0) begin
            @(negedge clk);
            k++;
            if (!seen && (who ? dma_gnt : cpu_gnt)) begin
                seen = 1'b1; lat_g = k;
                if (who) dma_req = 1'b0; else cpu_req = 1'b0;
            end
            if (seen && (who ? dma_done : cpu_done)) lat_d = k;
        end
        if (lat_d < 0) begin
            chk("txn_timeout", 32'(k), 32'(0));
            cpu_req = 1'b0; dma_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int lg, ld, w0, dn0, k;
        for (int i = 0; i < 4096; i++) begin mem[i] = '0; mmem[i] = '0; end
        mem[16'h0010] = 16'h1234; mmem[16'h0010] = 16'h1234;

        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_mem_rw", 32'(mem_rw), 32'd1);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b1;

        // contention straight after reset: CPU, DMA, CPU, DMA
        @(negedge clk);
        gq.delete();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 16'h1111;
        dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h0200; dma_wdata = 16'h2222;
        k = 0;
        while (k < 100 && gq.size() < 4) begin @(negedge clk); k++; end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("rr_count", 32'(gq.size()), 32'd4);
        if (gq.size() == 4) begin
            chk("rr_0", 32'(gq[0]), 32'd0);
            chk("rr_1", 32'(gq[1]), 32'd1);
            chk("rr_2", 32'(gq[2]), 32'd0);
            chk("rr_3", 32'(gq[3]), 32'd1);
        end
        repeat (4) @(negedge clk);

        // CPU read of preloaded word
        txn(1'b0, 1'b1, 16'h0010, 16'h0000, lg, ld);
        chk("rd_gnt_lat", 32'(lg), 32'd1);
        chk("rd_done_lat", 32'(ld), 32'(2 + RD_LAT));
        chk("rd_data", 32'(cpu_rdata), 32'h1234);
        chk("rd_err", 32'(cpu_err), 32'd0);
        chk("rd_dma_done", 32'(dma_done), 32'd0);

        // DMA write: one write-strobe cycle with the right address/data
        w0 = wr_n;
        txn(1'b1, 1'b0, 16'h0020, 16'hBEEF, lg, ld);
        chk("wr_done_lat", 32'(ld), 32'd2);
        chk("wr_strobes", 32'(wr_n - w0), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'h0020);
        chk("wr_dat", 32'(wr_dat), 32'hBEEF);

        txn(1'b0, 1'b1, 16'h0020, 16'h0000, lg, ld);
        chk("rdback", 32'(cpu_rdata), 32'hBEEF);

        // out-of-range write, then last legal address
        w0 = wr_n;
        txn(1'b0, 1'b0, 16'h1000, 16'hDEAD, lg, ld);
        chk("oor_err", 32'(cpu_err), 32'd1);
        chk("oor_done_lat", 32'(ld), 32'd2);
        chk("oor_no_write", 32'(wr_n - w0), 32'd0);
        txn(1'b0, 1'b0, 16'h0FFF, 16'h5A5A, lg, ld);
        chk("edge_err", 32'(cpu_err), 32'd0);
        chk("edge_write", 32'(wr_n - w0), 32'd1);

        // DMA read then errored DMA read clears rdata
        txn(1'b1, 1'b1, 16'h0020, 16'h0000, lg, ld);
        chk("dma_rd", 32'(dma_rdata), 32'hBEEF);
        txn(1'b1, 1'b1, 16'hFFFF, 16'h0000, lg, ld);
        chk("dma_oor_err", 32'(dma_err), 32'd1);
        chk("dma_oor_rdata", 32'(dma_rdata), 32'd0);

        // reset during WAIT_RD
        @(negedge clk);
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0010;
        k = 0;
        while (k < 20 && !cpu_gnt) begin @(negedge clk); k++; end
        chk("rst_gnt_seen", 32'(cpu_gnt), 32'd1);
        cpu_req = 1'b0;
        dn0 = cpu_done_n;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_rw", 32'(mem_rw), 32'd1);
        chk("async_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_rdata", 32'(cpu_rdata), 32'd0);
        chk("async_done", 32'(cpu_done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_after_rst", 32'(cpu_done_n - dn0), 32'd0);

        gq.delete();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0300; cpu_wdata = 16'h3333;
        dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h0400; dma_wdata = 16'h4444;
        k = 0;
        while (k < 20 && gq.size() == 0) begin @(negedge clk); k++; end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("rst_first_owner", 32'(gq.size() > 0 ? gq[0] : 9), 32'd0);
        repeat (4) @(negedge clk);

`ifdef ARB_PERF_CNT_EN
        txn(1'b0, 1'b0, 16'h1000, 16'h0001, lg, ld);
        txn(1'b1, 1'b1, 16'h3000, 16'h0000, lg, ld);
        @(negedge clk);
        chk("err_cnt", 32'(err_cnt), 32'd2);
        for (int i = 0; i < 300; i++) txn(1'b0, 1'b0, 16'(i), 16'(i), lg, ld);
        @(negedge clk);
        chk("cpu_gnt_cnt_sat", 32'(cpu_gnt_cnt), 32'd255);
        chk("dma_gnt_cnt", 32'(dma_gnt_cnt), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
